decode_cycle: RTL and testbench
===============================

Name: decode_cycle

Overview:
- Decode stage of the 5-stage RV32I-subset pipeline; consumes the IF/ID outputs InstrD, PCD and PCPlus4D.
- Decodes the instruction and reads the 32x32 register file, which is written by writeback.
- Resolves branches and jumps in decode and drives branchMuxSel/branchTarget back to the fetch stage.
- Registers all decode results into the ID/EX pipeline register.

Parameters:
- XLEN, 32, datapath width.
- NREGS, 32, architectural register count (x0 hardwired to zero).

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous active-low reset
- InstrD  in  32  instruction from IF/ID
- PCD  in  32  PC of InstrD
- PCPlus4D  in  32  PCD+4
- RegWriteW  in  1  writeback enable
- RDW  in  5  writeback destination
- ResultW  in  32  writeback data
- FlushE  in  1  hazard-unit request to bubble ID/EX
- branchMuxSel  out  1  redirect fetch (combinational)
- branchTarget  out  32  redirect PC = PCD + ImmExt (combinational)
- RD1E, RD2E  out  32  registered rs1/rs2 data
- ImmExtE  out  32  registered extended immediate
- RS1E, RS2E, RDE  out  5  registered register indices
- PCE, PCPlus4E  out  32  registered PCs
- RegWriteE, MemWriteE, ALUSrcE  out  1  registered controls
- ResultSrcE  out  2  encoding: 00 = ALU, 01 = memory, 10 = PC+4
- ALUControlE  out  3  encoding: 000 = add, 001 = sub, 010 = and, 011 = or, 101 = slt
- IllegalE  out  1  registered unsupported-opcode flag

Behaviour:
- Reset (rst=0 at posedge):
  - all ID/EX outputs become 0
  - all 31 writable registers become 0
  - squash_q becomes 0
  - branchMuxSel is forced to 0 combinationally while rst=0
- Supported instructions:
  - R-type 0110011: add, sub, and, or, slt
  - I-ALU 0010011: addi, andi, ori, slti
  - lw 0000011
  - sw 0100011
  - beq/bne 1100011 with funct3 000/001
  - jal 1101111
- Immediates, all sign-extended from InstrD[31]:
  - I: [31:20]
  - S: [31:25],[11:7]
  - B: [7],[30:25],[11:8],0
  - J: [19:12],[20],[30:21],0
- Register file:
  - write at posedge when RegWriteW=1 and RDW!=0; writes to x0 are ignored
  - reads are combinational
  - write-before-read bypass: if RegWriteW=1, RDW!=0 and RDW equals rs1/rs2, the read returns ResultW in that same cycle
- Branch resolution (combinational):
  - taken = valid & (jal | beq&(rd1==rd2) | bne&(rd1!=rd2))
  - branchMuxSel = taken
  - branchTarget = PCD + ImmExt, wrapping modulo 2^32
- Squash:
  - after a taken redirect, IF/ID holds the wrong-path instruction at PCD+4
  - squash_q <= taken at every posedge, cleared on reset
  - valid = ~squash_q
  - when squash_q=1, the current instruction produces no redirect and loads a bubble into ID/EX
- ID/EX update at each posedge:
  - loads a bubble if FlushE=1 or valid=0
  - otherwise loads the decoded values
  - a bubble is all controls 0, IllegalE=0, RDE=0, data fields 0
- Latency: one cycle from InstrD to the E outputs; redirect is zero-cycle combinational.
- Illegal/zero instructions:
  - InstrD=0 (fetch reset/bubble) decodes as a bubble with IllegalE=0
  - any other unsupported opcode/funct loads a bubble with IllegalE=1
- Simultaneous events:
  - FlushE with a taken branch: the redirect still happens and squash_q is still set; only ID/EX is bubbled
  - squash_q=1 with a decoded branch: the branch is ignored
- jal sets RegWriteE=1 and ResultSrcE=10.
- lw sets ALUSrcE=1, ResultSrcE=01, RegWriteE=1.
- sw sets ALUSrcE=1, MemWriteE=1.
- Branches: all write enables are 0; ALUControlE=001.

Decomposition:
- Shared package riscv_pkg holds:
  - opcode constants
  - funct3/funct7 values
  - ALUControl encodings
  - ResultSrc encodings
  - immediate-type enum
- One sub-module, register_file:
  - 2 combinational read ports, 1 write port, with bypass
  - synchronous active-low reset
- Control decode and immediate generation stay inline.

Test Plan:
- Reset: hold rst=0 for 2 cycles with InstrD=0x00500093 → all E outputs 0 and branchMuxSel=0; after release, addi x1,x0,5 gives ImmExtE=5, RDE=1, RegWriteE=1, ALUSrcE=1.
- Writeback bypass: RegWriteW=1, RDW=3, ResultW=0xDEADBEEF with InstrD=add x4,x3,x0 (0x00018233) → RD1E=0xDEADBEEF. Repeat with RDW=0 → no write, x0 reads 0.
- Taken beq:
  - setup: x1=x2=7, PCD=0x100, beq x1,x2,+16 (0x00208863)
  - branchMuxSel=1 and branchTarget=0x110 in the same cycle
  - next cycle, InstrD at 0x104 produces a bubble and branchMuxSel=0, even if it is itself a taken jal
- jal x1,-8 at PCD=0x20 → branchTarget=0x18, PCPlus4E=0x24, ResultSrcE=10, RDE=1.
- FlushE=1 with a valid lw → ID/EX all zero.
- Illegal opcode 0x0000007F → IllegalE=1, controls 0.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared decode definitions for the RV32I-subset pipeline: opcodes, funct
// fields, control encodings, the ID/EX payload and the immediate generator.
package riscv_pkg;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BR  = 7'b1100011;
   localparam logic [6:0] OP_JAL = 7'b1101111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;
   localparam logic [2:0] F3_BEQ = 3'b000;
   localparam logic [2:0] F3_BNE = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_SLT = 3'b101
   } alu_ctl_e;

   typedef enum logic [1:0] {
      RES_ALU = 2'b00,
      RES_MEM = 2'b01,
      RES_PC4 = 2'b10
   } result_src_e;

   typedef enum logic [1:0] {
      IMM_I = 2'b00,
      IMM_S = 2'b01,
      IMM_B = 2'b10,
      IMM_J = 2'b11
   } imm_sel_e;

   // Everything the execute stage receives; a bubble is this struct all-zero.
   typedef struct packed {
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic            reg_write;
      logic            mem_write;
      logic            alu_src;
      result_src_e     result_src;
      alu_ctl_e        alu_control;
      logic            illegal;
   } id_ex_t;

   // Sign-extended immediate for each instruction format.
   function automatic logic [XLEN-1:0] imm_ext(input logic [31:0] instr,
                                               input imm_sel_e sel);
      logic [XLEN-1:0] imm;
      case (sel)
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_J:   imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = {{20{instr[31]}}, instr[31:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/decode_cycle_if.sv
// Fetch <-> decode bus: the IF/ID instruction/PC going in and the fetch
// redirect coming back. The redirect has no handshake: when branchMuxSel is
// high in a cycle, fetch must take branchTarget at the next posedge.
interface decode_cycle_if;
   import riscv_pkg::*;

   logic [XLEN-1:0] InstrD;
   logic [XLEN-1:0] PCD;
   logic [XLEN-1:0] PCPlus4D;
   logic            branchMuxSel;
   logic [XLEN-1:0] branchTarget;

   modport master (output InstrD, PCD, PCPlus4D, input branchMuxSel, branchTarget);
   modport slave  (input InstrD, PCD, PCPlus4D, output branchMuxSel, branchTarget);
endinterface

// File: rtl/decode_cycle_register_file.sv
// 32x32 architectural register file: two combinational read ports, one
// write port, and a same-cycle bypass so decode sees writeback data at once.
module register_file
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   input  logic            we,
   input  logic [4:0]      wa,
   input  logic [XLEN-1:0] wd,
   input  logic [4:0]      ra1,
   input  logic [4:0]      ra2,
   output logic [XLEN-1:0] rd1,
   output logic [XLEN-1:0] rd2
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_en;

   assign wr_en = we && (wa != 5'd0);

   // Register writes; x0 is never written so it stays at its reset zero.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else if (wr_en) begin
         regs[wa] <= wd;
      end
   end

   // Reads: x0 is always zero, a matching writeback is forwarded.
   always_comb begin
      rd1 = regs[ra1];
      rd2 = regs[ra2];
      if (ra1 == 5'd0)                rd1 = '0;
      else if (wr_en && (wa == ra1))  rd1 = wd;
      if (ra2 == 5'd0)                rd2 = '0;
      else if (wr_en && (wa == ra2))  rd2 = wd;
   end

endmodule

// File: rtl/decode_cycle.sv
// Decode stage: control decode, immediate generation, register read,
// branch/jump resolution with fetch redirect, and the ID/EX register.
module decode_cycle
   import riscv_pkg::*;
(
   input  logic            clk,
   input  logic            rst,
   decode_cycle_if.slave   fd,
   input  logic            RegWriteW,
   input  logic [4:0]      RDW,
   input  logic [XLEN-1:0] ResultW,
   input  logic            FlushE,
   output logic [XLEN-1:0] RD1E,
   output logic [XLEN-1:0] RD2E,
   output logic [XLEN-1:0] ImmExtE,
   output logic [4:0]      RS1E,
   output logic [4:0]      RS2E,
   output logic [4:0]      RDE,
   output logic [XLEN-1:0] PCE,
   output logic [XLEN-1:0] PCPlus4E,
   output logic            RegWriteE,
   output logic            MemWriteE,
   output logic            ALUSrcE,
   output logic [1:0]      ResultSrcE,
   output logic [2:0]      ALUControlE,
   output logic            IllegalE
);

   logic [6:0]      opcode, funct7;
   logic [2:0]      funct3;
   logic [4:0]      rs1, rs2, rd;
   logic [XLEN-1:0] rd1, rd2, imm;

   logic        legal, has_rd, is_jal, is_beq, is_bne;
   logic        reg_write, mem_write, alu_src;
   result_src_e result_src;
   alu_ctl_e    alu_control;
   imm_sel_e    imm_sel;

   logic   squash_q, valid, taken;
   id_ex_t ex_d, ex_q;

   assign opcode = fd.InstrD[6:0];
   assign rd     = fd.InstrD[11:7];
   assign funct3 = fd.InstrD[14:12];
   assign rs1    = fd.InstrD[19:15];
   assign rs2    = fd.InstrD[24:20];
   assign funct7 = fd.InstrD[31:25];

   register_file u_rf (
      .clk (clk),
      .rst (rst),
      .we  (RegWriteW),
      .wa  (RDW),
      .wd  (ResultW),
      .ra1 (rs1),
      .ra2 (rs2),
      .rd1 (rd1),
      .rd2 (rd2)
   );

   // Control decode; anything not matched below stays illegal.
   always_comb begin
      legal       = 1'b1;
      has_rd      = 1'b0;
      is_jal      = 1'b0;
      is_beq      = 1'b0;
      is_bne      = 1'b0;
      reg_write   = 1'b0;
      mem_write   = 1'b0;
      alu_src     = 1'b0;
      result_src  = RES_ALU;
      alu_control = ALU_ADD;
      imm_sel     = IMM_I;
      case (opcode)
         OP_R: begin
            reg_write = 1'b1;
            has_rd    = 1'b1;
            if (funct7 == F7_BASE) begin
               case (funct3)
                  F3_ADD:  alu_control = ALU_ADD;
                  F3_SLT:  alu_control = ALU_SLT;
                  F3_OR:   alu_control = ALU_OR;
                  F3_AND:  alu_control = ALU_AND;
                  default: legal = 1'b0;
               endcase
            end else if (funct7 == F7_SUB && funct3 == F3_ADD) begin
               alu_control = ALU_SUB;
            end else begin
               legal = 1'b0;
            end
         end
         OP_I: begin
            reg_write = 1'b1;
            has_rd    = 1'b1;
            alu_src   = 1'b1;
            case (funct3)
               F3_ADD:  alu_control = ALU_ADD;
               F3_SLT:  alu_control = ALU_SLT;
               F3_OR:   alu_control = ALU_OR;
               F3_AND:  alu_control = ALU_AND;
               default: legal = 1'b0;
            endcase
         end
         OP_LW: begin
            reg_write  = 1'b1;
            has_rd     = 1'b1;
            alu_src    = 1'b1;
            result_src = RES_MEM;
            legal      = (funct3 == F3_W);
         end
         OP_SW: begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
            imm_sel   = IMM_S;
            legal     = (funct3 == F3_W);
         end
         OP_BR: begin
            alu_control = ALU_SUB;
            imm_sel     = IMM_B;
            is_beq      = (funct3 == F3_BEQ);
            is_bne      = (funct3 == F3_BNE);
            legal       = is_beq || is_bne;
         end
         OP_JAL: begin
            reg_write  = 1'b1;
            has_rd     = 1'b1;
            result_src = RES_PC4;
            imm_sel    = IMM_J;
            is_jal     = 1'b1;
         end
         default: legal = 1'b0;
      endcase
   end

   assign imm   = imm_ext(fd.InstrD, imm_sel);
   assign valid = ~squash_q;
   // Redirect is suppressed during reset and for the wrong-path slot.
   assign taken = rst && valid &&
                  (is_jal || (is_beq && (rd1 == rd2)) || (is_bne && (rd1 != rd2)));

   assign fd.branchMuxSel = taken;
   assign fd.branchTarget = fd.PCD + imm;

   // Remember a redirect so the following (wrong-path) instruction is dropped.
   always_ff @(posedge clk) begin
      if (!rst) squash_q <= 1'b0;
      else      squash_q <= taken;
   end

   // Next ID/EX contents: bubble unless a valid, unflushed instruction decodes.
   always_comb begin
      ex_d = '0;
      if (valid && !FlushE) begin
         if (legal) begin
            ex_d.rd1         = rd1;
            ex_d.rd2         = rd2;
            ex_d.imm         = imm;
            ex_d.rs1         = rs1;
            ex_d.rs2         = rs2;
            ex_d.rd          = has_rd ? rd : 5'd0;
            ex_d.pc          = fd.PCD;
            ex_d.pc4         = fd.PCPlus4D;
            ex_d.reg_write   = reg_write;
            ex_d.mem_write   = mem_write;
            ex_d.alu_src     = alu_src;
            ex_d.result_src  = result_src;
            ex_d.alu_control = alu_control;
         end else begin
            // An all-zero word is a fetch bubble, not an illegal instruction.
            ex_d.illegal = (fd.InstrD != '0);
         end
      end
   end

   // ID/EX pipeline register.
   always_ff @(posedge clk) begin
      if (!rst) ex_q <= '0;
      else      ex_q <= ex_d;
   end

   assign RD1E        = ex_q.rd1;
   assign RD2E        = ex_q.rd2;
   assign ImmExtE     = ex_q.imm;
   assign RS1E        = ex_q.rs1;
   assign RS2E        = ex_q.rs2;
   assign RDE         = ex_q.rd;
   assign PCE         = ex_q.pc;
   assign PCPlus4E    = ex_q.pc4;
   assign RegWriteE   = ex_q.reg_write;
   assign MemWriteE   = ex_q.mem_write;
   assign ALUSrcE     = ex_q.alu_src;
   assign ResultSrcE  = ex_q.result_src;
   assign ALUControlE = ex_q.alu_control;
   assign IllegalE    = ex_q.illegal;

endmodule

// File: tb/tb_decode_cycle.sv
// Directed bench for decode_cycle with hand-computed expected values.
module tb_decode_cycle;
   import riscv_pkg::*;

   logic            clk;
   logic            rst;
   logic            RegWriteW;
   logic [4:0]      RDW;
   logic [31:0]     ResultW;
   logic            FlushE;
   logic [31:0]     RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
   logic [4:0]      RS1E, RS2E, RDE;
   logic            RegWriteE, MemWriteE, ALUSrcE, IllegalE;
   logic [1:0]      ResultSrcE;
   logic [2:0]      ALUControlE;

   int checks = 0;
   int errors = 0;

   decode_cycle_if fd ();

   decode_cycle dut (
      .clk         (clk),
      .rst         (rst),
      .fd          (fd),
      .RegWriteW   (RegWriteW),
      .RDW         (RDW),
      .ResultW     (ResultW),
      .FlushE      (FlushE),
      .RD1E        (RD1E),
      .RD2E        (RD2E),
      .ImmExtE     (ImmExtE),
      .RS1E        (RS1E),
      .RS2E        (RS2E),
      .RDE         (RDE),
      .PCE         (PCE),
      .PCPlus4E    (PCPlus4E),
      .RegWriteE   (RegWriteE),
      .MemWriteE   (MemWriteE),
      .ALUSrcE     (ALUSrcE),
      .ResultSrcE  (ResultSrcE),
      .ALUControlE (ALUControlE),
      .IllegalE    (IllegalE)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one cycle; inputs are changed and outputs sampled 1ns after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
      fd.InstrD   = instr;
      fd.PCD      = pc;
      fd.PCPlus4D = pc + 32'd4;
   endtask

   task automatic settle();
      #2;
   endtask

   initial begin
      rst = 1'b0; RegWriteW = 1'b0; RDW = '0; ResultW = '0; FlushE = 1'b0;
      drive(32'h00500093, 32'h0);

      // Reset held for two cycles
      tick(); tick();
      settle();
      check("rst_mux",   {31'd0, fd.branchMuxSel}, 32'd0);
      check("rst_imm",   ImmExtE, 32'd0);
      check("rst_rde",   {27'd0, RDE}, 32'd0);
      check("rst_ctl",   {25'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, IllegalE, 1'b0}, 32'd0);
      check("rst_pc4",   PCPlus4E, 32'd0);

      // addi x1,x0,5 after release
      rst = 1'b1;
      tick();
      check("addi_imm",  ImmExtE, 32'd5);
      check("addi_rde",  {27'd0, RDE}, 32'd1);
      check("addi_rw",   {31'd0, RegWriteE}, 32'd1);
      check("addi_src",  {31'd0, ALUSrcE}, 32'd1);
      check("addi_alu",  {29'd0, ALUControlE}, 32'd0);

      // Writeback bypass into add x4,x3,x0
      RegWriteW = 1'b1; RDW = 5'd3; ResultW = 32'hDEADBEEF;
      drive(32'h00018233, 32'h8);
      tick();
      check("byp_rd1",   RD1E, 32'hDEADBEEF);
      check("byp_rde",   {27'd0, RDE}, 32'd4);
      check("byp_rs1",   {27'd0, RS1E}, 32'd3);
      // Same read from the stored register, no bypass
      RegWriteW = 1'b0;
      tick();
      check("x3_stored", RD1E, 32'hDEADBEEF);
      // Write to x0 is ignored: add x5,x0,x0
      RegWriteW = 1'b1; RDW = 5'd0; ResultW = 32'h12345678;
      drive(32'h000002B3, 32'hC);
      tick();
      check("x0_byp",    RD1E, 32'd0);
      RegWriteW = 1'b0;
      tick();
      check("x0_read",   RD2E, 32'd0);

      // x1 = x2 = 7 with zero instruction in decode
      RegWriteW = 1'b1; RDW = 5'd1; ResultW = 32'd7;
      drive(32'h0, 32'h10);
      tick();
      RDW = 5'd2;
      tick();
      RegWriteW = 1'b0;
      check("zero_ill",  {31'd0, IllegalE}, 32'd0);
      check("zero_rw",   {31'd0, RegWriteE}, 32'd0);

      // Taken beq x1,x2,+16 at 0x100
      drive(32'h00208863, 32'h100);
      settle();
      check("beq_mux",   {31'd0, fd.branchMuxSel}, 32'd1);
      check("beq_tgt",   fd.branchTarget, 32'h110);
      tick();
      check("beq_alu",   {29'd0, ALUControlE}, 32'd1);
      check("beq_we",    {30'd0, RegWriteE, MemWriteE}, 32'd0);
      check("beq_pce",   PCE, 32'h100);
      check("beq_imm",   ImmExtE, 32'd16);

      // Wrong-path jal at 0x104 is squashed
      drive(32'hFF9FF0EF, 32'h104);
      settle();
      check("sq_mux",    {31'd0, fd.branchMuxSel}, 32'd0);
      tick();
      check("sq_rw",     {31'd0, RegWriteE}, 32'd0);
      check("sq_pce",    PCE, 32'd0);

      // jal x1,-8 at 0x20
      drive(32'hFF9FF0EF, 32'h20);
      settle();
      check("jal_mux",   {31'd0, fd.branchMuxSel}, 32'd1);
      check("jal_tgt",   fd.branchTarget, 32'h18);
      tick();
      check("jal_pc4",   PCPlus4E, 32'h24);
      check("jal_res",   {30'd0, ResultSrcE}, 32'd2);
      check("jal_rde",   {27'd0, RDE}, 32'd1);
      check("jal_rw",    {31'd0, RegWriteE}, 32'd1);
      check("jal_imm",   ImmExtE, 32'hFFFFFFF8);

      // lw x6,4(x1) is the squashed slot after jal
      drive(32'h0040A303, 32'h24);
      tick();
      check("sq2_rw",    {31'd0, RegWriteE}, 32'd0);
      // Same lw with FlushE
      FlushE = 1'b1;
      drive(32'h0040A303, 32'h40);
      tick();
      check("fl_ctl",    {26'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, IllegalE}, 32'd0);
      check("fl_imm",    ImmExtE, 32'd0);
      check("fl_pce",    PCE, 32'd0);
      check("fl_rd1",    RD1E, 32'd0);
      // Same lw unflushed
      FlushE = 1'b0;
      tick();
      check("lw_src",    {30'd0, ResultSrcE}, 32'd1);
      check("lw_ctl",    {29'd0, RegWriteE, MemWriteE, ALUSrcE}, 32'h5);
      check("lw_imm",    ImmExtE, 32'd4);
      check("lw_rd1",    RD1E, 32'd7);
      check("lw_rde",    {27'd0, RDE}, 32'd6);

      // sw x2,-4(x1)
      drive(32'hFE20AE23, 32'h44);
      tick();
      check("sw_ctl",    {29'd0, RegWriteE, MemWriteE, ALUSrcE}, 32'h3);
      check("sw_imm",    ImmExtE, 32'hFFFFFFFC);
      check("sw_rd2",    RD2E, 32'd7);

      // sub x7,x1,x2
      drive(32'h402083B3, 32'h48);
      tick();
      check("sub_alu",   {29'd0, ALUControlE}, 32'd1);
      check("sub_rde",   {27'd0, RDE}, 32'd7);

      // slti x8,x1,-1
      drive(32'hFFF0A413, 32'h4C);
      tick();
      check("slti_alu",  {29'd0, ALUControlE}, 32'd5);
      check("slti_imm",  ImmExtE, 32'hFFFFFFFF);

      // bne x1,x2 with equal operands: not taken
      drive(32'h00209863, 32'h50);
      settle();
      check("bne_mux",   {31'd0, fd.branchMuxSel}, 32'd0);
      tick();

      // Illegal opcode
      drive(32'h0000007F, 32'h54);
      tick();
      check("ill_flag",  {31'd0, IllegalE}, 32'd1);
      check("ill_ctl",   {26'd0, RegWriteE, MemWriteE, ALUSrcE, ResultSrcE, 1'b0}, 32'd0);
      FlushE = 1'b1;
      tick();
      check("ill_flush", {31'd0, IllegalE}, 32'd0);

      // FlushE with a taken beq: redirect still happens, slot after is squashed
      drive(32'h00208863, 32'h100);
      settle();
      check("flb_mux",   {31'd0, fd.branchMuxSel}, 32'd1);
      tick();
      check("flb_alu",   {29'd0, ALUControlE}, 32'd0);
      FlushE = 1'b0;
      drive(32'hFF9FF0EF, 32'h104);
      settle();
      check("flb_sq",    {31'd0, fd.branchMuxSel}, 32'd0);
      tick();
      check("flb_rw",    {31'd0, RegWriteE}, 32'd0);

      // Redirect suppressed during reset
      rst = 1'b0;
      drive(32'hFF9FF0EF, 32'h20);
      settle();
      check("rst_jal",   {31'd0, fd.branchMuxSel}, 32'd0);
      tick();
      check("rst_rw2",   {31'd0, RegWriteE}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
